// File: rtl/regbank_pkg.sv
// Shared types and widths for the dual-master register bank.
package regbank_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   typedef enum logic [1:0] {
      IDLE,
      OWN0,
      OWN1
   } state_e;

endpackage

// File: rtl/regbank_word.sv
// One 32-bit register with per-byte write enables and synchronous clear.
module regbank_word
   import regbank_pkg::*;
(
   input  logic              clock,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [BE_W-1:0]   byteenable,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] word_d, word_q;

   always_comb begin
      word_d = word_q;
      if (wr_en) begin
         for (int k = 0; k < int'(BE_W); k++) begin
            if (byteenable[k]) word_d[8*k +: 8] = wdata[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (clear) word_q <= '0;
      else       word_q <= word_d;
   end

   assign q = word_q;

endmodule

// File: rtl/regbank_arbiter.sv
// Two-master register bank with round-robin arbitration and lock-based ownership.
module regbank_arbiter
   import regbank_pkg::*;
#(
   parameter int unsigned ADDR_W = 2,
   localparam int unsigned NREG  = 1 << ADDR_W
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     m0_read,
   input  logic                     m0_write,
   input  logic                     m0_lock,
   input  logic [ADDR_W-1:0]        m0_address,
   input  logic [BE_W-1:0]          m0_byteenable,
   input  logic [DATA_W-1:0]        m0_writedata,
   output logic                     m0_waitrequest,
   output logic [DATA_W-1:0]        m0_readdata,
   output logic                     m0_readdatavalid,
   input  logic                     m1_read,
   input  logic                     m1_write,
   input  logic                     m1_lock,
   input  logic [ADDR_W-1:0]        m1_address,
   input  logic [BE_W-1:0]          m1_byteenable,
   input  logic [DATA_W-1:0]        m1_writedata,
   output logic                     m1_waitrequest,
   output logic [DATA_W-1:0]        m1_readdata,
   output logic                     m1_readdatavalid,
   output logic [DATA_W*NREG-1:0]   regs_q
);

   state_e            state_d, state_q;
   logic              last_grant_d, last_grant_q;
   logic [1:0]        req, gnt;

   logic [ADDR_W-1:0] acc_addr;
   logic [BE_W-1:0]   acc_be;
   logic [DATA_W-1:0] acc_wdata;
   logic              acc_write;
   logic [DATA_W-1:0] word_q [NREG];

   logic              rvalid0_d, rvalid0_q, rvalid1_d, rvalid1_q;
   logic [DATA_W-1:0] rdata0_d, rdata0_q, rdata1_d, rdata1_q;

   assign req = {m1_read | m1_write, m0_read | m0_write};

   // Grant selection and ownership FSM.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt          = 2'b00;
      if (!reset) begin
         unique case (state_q)
            IDLE: begin
               if (req == 2'b11) gnt = last_grant_q ? 2'b01 : 2'b10;
               else              gnt = req;
               if (gnt[0] && m0_lock)      state_d = OWN0;
               else if (gnt[1] && m1_lock) state_d = OWN1;
            end
            OWN0: begin
               gnt = {1'b0, req[0]};
               if (!m0_lock) state_d = IDLE;
            end
            OWN1: begin
               gnt = {req[1], 1'b0};
               if (!m1_lock) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
         if (gnt[0])      last_grant_d = 1'b0;
         else if (gnt[1]) last_grant_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign m0_waitrequest = req[0] & ~gnt[0];
   assign m1_waitrequest = req[1] & ~gnt[1];

   assign acc_addr  = gnt[1] ? m1_address    : m0_address;
   assign acc_be    = gnt[1] ? m1_byteenable : m0_byteenable;
   assign acc_wdata = gnt[1] ? m1_writedata  : m0_writedata;
   assign acc_write = (gnt[0] & m0_write) | (gnt[1] & m1_write);

   for (genvar i = 0; i < int'(NREG); i++) begin : g_word
      regbank_word u_word (
         .clock      (clock),
         .clear      (reset),
         .wr_en      (acc_write && (acc_addr == ADDR_W'(i))),
         .byteenable (acc_be),
         .wdata      (acc_wdata),
         .q          (word_q[i])
      );
      assign regs_q[DATA_W*i +: DATA_W] = word_q[i];
   end

   // Read return path: pre-edge register value, one cycle after grant.
   always_comb begin
      rvalid0_d = gnt[0] & m0_read & ~m0_write;
      rvalid1_d = gnt[1] & m1_read & ~m1_write;
      rdata0_d  = rvalid0_d ? word_q[acc_addr] : rdata0_q;
      rdata1_d  = rvalid1_d ? word_q[acc_addr] : rdata1_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   // A pending read return is suppressed in a cycle where reset is asserted.
   assign m0_readdatavalid = rvalid0_q & ~reset;
   assign m1_readdatavalid = rvalid1_q & ~reset;
   assign m0_readdata      = rdata0_q;
   assign m1_readdata      = rdata1_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed plus randomized checks of regbank_arbiter against a behavioural model.
module tb_regbank_arbiter;

   localparam int unsigned ADDR_W = 2;
   localparam int unsigned NREG   = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic              rd [2];
   logic              wr [2];
   logic              lk [2];
   logic [ADDR_W-1:0] ad [2];
   logic [3:0]        be [2];
   logic [31:0]       wd [2];

   logic              w0, w1, v0, v1;
   logic [31:0]       d0, d1;
   logic [32*NREG-1:0] regs_q;

   logic [31:0]       mregs [NREG];
   logic              mv  [2];
   logic [31:0]       mrd [2];
   int                owner, last;
   int                checks = 0;
   int                errors = 0;

   always #5 clock = ~clock;

   regbank_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clock            (clock),
      .reset            (reset),
      .m0_read          (rd[0]),
      .m0_write         (wr[0]),
      .m0_lock          (lk[0]),
      .m0_address       (ad[0]),
      .m0_byteenable    (be[0]),
      .m0_writedata     (wd[0]),
      .m0_waitrequest   (w0),
      .m0_readdata      (d0),
      .m0_readdatavalid (v0),
      .m1_read          (rd[1]),
      .m1_write         (wr[1]),
      .m1_lock          (lk[1]),
      .m1_address       (ad[1]),
      .m1_byteenable    (be[1]),
      .m1_writedata     (wd[1]),
      .m1_waitrequest   (w1),
      .m1_readdata      (d1),
      .m1_readdatavalid (v1),
      .regs_q           (regs_q)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      for (int m = 0; m < 2; m++) begin
         rd[m] = 1'b0; wr[m] = 1'b0; lk[m] = 1'b0;
         ad[m] = '0;   be[m] = 4'h0; wd[m] = 32'h0;
      end
   endtask

   // Checks outputs for the current inputs, clocks once, then advances the model.
   task automatic cycle(input bit en);
      int           g;
      bit           rq [2];
      logic [127:0] er;
      #2;
      for (int m = 0; m < 2; m++) rq[m] = rd[m] || wr[m];
      g = -1;
      if (!reset) begin
         if (owner >= 0) begin
            if (rq[owner]) g = owner;
         end else if (rq[0] && rq[1]) g = 1 - last;
         else if (rq[0]) g = 0;
         else if (rq[1]) g = 1;
      end
      if (en) begin
         er = '0;
         for (int i = 0; i < int'(NREG); i++) er[32*i +: 32] = mregs[i];
         chk("wait0", 128'(w0), 128'(rq[0] && g != 0));
         chk("wait1", 128'(w1), 128'(rq[1] && g != 1));
         chk("rvalid0", 128'(v0), 128'(mv[0] && !reset));
         chk("rvalid1", 128'(v1), 128'(mv[1] && !reset));
         chk("rdata0", 128'(d0), 128'(mrd[0]));
         chk("rdata1", 128'(d1), 128'(mrd[1]));
         chk("regs", 128'(regs_q), er);
      end
      @(posedge clock);
      mv[0] = 1'b0;
      mv[1] = 1'b0;
      if (reset) begin
         for (int i = 0; i < int'(NREG); i++) mregs[i] = 32'h0;
         mrd[0] = 32'h0; mrd[1] = 32'h0;
         owner = -1; last = 1;
      end else begin
         if (g >= 0) begin
            if (wr[g]) begin
               for (int k = 0; k < 4; k++)
                  if (be[g][k]) mregs[ad[g]][8*k +: 8] = wd[g][8*k +: 8];
            end else begin
               mrd[g] = mregs[ad[g]];
               mv[g]  = 1'b1;
            end
         end
         if (owner >= 0) begin
            if (!lk[owner]) owner = -1;
         end else if (g >= 0 && lk[g]) owner = g;
         if (g >= 0) last = g;
      end
      #1;
   endtask

   initial begin
      owner = -1; last = 1;
      mv[0] = 1'b0; mv[1] = 1'b0; mrd[0] = 32'h0; mrd[1] = 32'h0;
      for (int i = 0; i < int'(NREG); i++) mregs[i] = 32'h0;
      idle();
      reset = 1'b1;
      @(negedge clock);
      cycle(0);
      cycle(1);
      reset = 1'b0;
      chk("reset_regs", 128'(regs_q), 128'h0);

      // Full-word write then read back on master 0.
      idle(); wr[0] = 1'b1; ad[0] = 2'd1; wd[0] = 32'hDEADBEEF; be[0] = 4'hF;
      cycle(1);
      chk("word1_written", 128'(regs_q[63:32]), 128'h0DEADBEEF);
      idle(); rd[0] = 1'b1; ad[0] = 2'd1;
      cycle(1);
      idle();
      chk("read_valid", 128'(v0), 128'h1);
      chk("read_data", 128'(d0), 128'h0DEADBEEF);
      cycle(1);

      // Byte-enable merge and empty byte-enable.
      idle(); wr[1] = 1'b1; ad[1] = 2'd2; wd[1] = 32'h11223344; be[1] = 4'hF;
      cycle(1);
      wd[1] = 32'hAABBCCDD; be[1] = 4'b0101;
      cycle(1);
      chk("byte_merge", 128'(regs_q[95:64]), 128'h11BB33DD);
      wd[1] = 32'hFFFFFFFF; be[1] = 4'b0000;
      #2;
      chk("be0_wait", 128'(w1), 128'h0);
      cycle(1);
      chk("be0_noop", 128'(regs_q[95:64]), 128'h11BB33DD);

      // Round-robin from reset with both masters writing.
      idle(); reset = 1'b1;
      cycle(1);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         wr[0] = 1'b1; ad[0] = 2'd0; be[0] = 4'hF; wd[0] = 32'(c);
         wr[1] = 1'b1; ad[1] = 2'd3; be[1] = 4'hF; wd[1] = 32'(c + 100);
         #2;
         chk("rr_wait0", 128'(w0), 128'(c % 2));
         chk("rr_wait1", 128'(w1), 128'(1 - (c % 2)));
         cycle(1);
      end

      // Master 1 locks for three cycles while master 0 waits.
      idle(); wr[1] = 1'b1; lk[1] = 1'b1; ad[1] = 2'd1; be[1] = 4'hF; wd[1] = 32'h0000_0101;
      cycle(1);
      wr[0] = 1'b1; ad[0] = 2'd2; be[0] = 4'hF; wd[0] = 32'h0000_0202;
      cycle(1);
      cycle(1);
      lk[1] = 1'b0;
      cycle(1);
      wr[1] = 1'b0;
      #2;
      chk("unlock_grant0", 128'(w0), 128'h0);
      cycle(1);

      // Reset right after a granted read abandons the return.
      idle(); rd[0] = 1'b1; ad[0] = 2'd1; lk[0] = 1'b1;
      cycle(1);
      rd[0] = 1'b0; wr[0] = 1'b1; wr[1] = 1'b1; be[0] = 4'hF; be[1] = 4'hF;
      wd[0] = 32'h12345678; wd[1] = 32'h87654321;
      reset = 1'b1;
      #2;
      chk("reset_rvalid", 128'(v0), 128'h0);
      cycle(1);
      reset = 1'b0;
      chk("post_reset_regs", 128'(regs_q), 128'h0);
      lk[0] = 1'b0;
      #2;
      chk("tie_after_reset", 128'({w1, w0}), 128'b10);
      cycle(1);

      // Read and write together count as a write.
      idle(); rd[0] = 1'b1; wr[0] = 1'b1; ad[0] = 2'd0; be[0] = 4'hF; wd[0] = 32'h5A5A5A5A;
      cycle(1);
      idle();
      chk("rw_word0", 128'(regs_q[31:0]), 128'h5A5A5A5A);
      chk("rw_no_valid", 128'(v0), 128'h0);
      cycle(1);

      for (int n = 0; n < 400; n++) begin
         reset = ($urandom % 40) == 0;
         for (int m = 0; m < 2; m++) begin
            rd[m] = ($urandom % 3) == 0;
            wr[m] = ($urandom % 3) == 0;
            lk[m] = ($urandom % 4) == 0;
            ad[m] = ADDR_W'($urandom);
            be[m] = 4'($urandom);
            wd[m] = $urandom;
         end
         cycle(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regbank_arbiter.md
REGBANK_ARBITER -- requirements
Module: regbank_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 2: register index width; NREG = 2**ADDR_W 32-bit registers.
REQ-002 SHALL have port clock, in, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, in, 1: synchronous, active-high reset.
REQ-004 SHALL have per master x in {0,1}: mx_read in 1, mx_write in 1, mx_lock in 1, mx_address in ADDR_W, mx_byteenable in 4, mx_writedata in 32.
REQ-005 SHALL have per master x: mx_waitrequest out 1, mx_readdata out 32, mx_readdatavalid out 1.
REQ-006 SHALL have port regs_q, out, 32*NREG: live contents of all registers; register i at bits [32*i+31:32*i].

Function
REQ-007 SHALL treat master x as requesting when mx_read or mx_write is high; read+write together SHALL be a write, with no readdatavalid.
REQ-008 SHALL grant at most one master per cycle; mx_waitrequest SHALL be low combinationally only in the cycle master x is granted, and high whenever x requests but is not granted.
REQ-009 SHALL hold mx_waitrequest low when master x is not requesting.
REQ-010 FSM states SHALL be IDLE, OWN0, OWN1.
REQ-011 In IDLE with one requester, SHALL grant it; with both, SHALL grant the master not in last_grant (round-robin); last_grant SHALL update to the granted master.
REQ-012 In IDLE, if the granted master has mx_lock high, SHALL go to OWNx at the next edge; otherwise stay in IDLE.
REQ-013 In OWNx, SHALL grant only master x; the other master SHALL wait regardless of request.
REQ-014 In OWNx, SHALL return to IDLE at the edge of the first cycle with mx_lock low, whether or not x is requesting; that cycle's request by x SHALL still be granted.
REQ-015 A granted write SHALL update, at the next edge, only the bytes of register mx_address whose mx_byteenable bit is high (bit k -> bits [8k+7:8k]); byteenable 4'b0000 SHALL be a granted no-op.
REQ-016 A granted read SHALL drive mx_readdata with the register value before that edge and assert mx_readdatavalid for exactly one cycle, one cycle after the grant (latency 1).
REQ-017 mx_readdata SHALL hold its last value when mx_readdatavalid is low.
REQ-018 A read granted in the cycle after a write to the same register SHALL return the written value.
REQ-019 Back-to-back grants SHALL be allowed: one access per cycle, full throughput.
REQ-020 regs_q SHALL reflect the register state directly (no extra latency).

Reset
REQ-021 With reset high at an edge: all registers SHALL be 32'h0, FSM SHALL be IDLE, last_grant SHALL be 1 (master 0 wins the first tie), both readdatavalid 0, both readdata 32'h0.
REQ-022 While reset is high, no grant SHALL be given: both mx_waitrequest high if requesting, no writes, no readdatavalid.
REQ-023 Reset asserted mid-lock SHALL abandon ownership; a read granted in the cycle before reset SHALL NOT produce readdatavalid in the reset cycle.

Structure
REQ-024 Shared package regbank_pkg SHALL hold the FSM state enum (IDLE, OWN0, OWN1), DATA_W=32 and BE_W=4.
REQ-025 One sub-module, regbank_word, SHALL implement one 32-bit register with write enable, per-byte enables and synchronous active-high clear; it SHALL be instantiated NREG times.
REQ-026 Arbitration and FSM SHALL stay in regbank_arbiter; no other sub-modules.

Verification
REQ-027 Reset, then m0 write addr 1, data 32'hDEADBEEF, be 4'hF -> regs_q word1 = 32'hDEADBEEF next cycle; m0 read addr 1 -> m0_readdata = 32'hDEADBEEF with readdatavalid 1 one cycle later.
REQ-028 Word2 = 32'h11223344, m1 write 32'hAABBCCDD be 4'b0101 -> word2 = 32'h11BB33DD; be 4'b0000 -> unchanged, waitrequest low.
REQ-029 Both masters request writes continuously for 4 cycles from reset -> grants in order m0, m1, m0, m1; the waiting master's waitrequest is high in each cycle.
REQ-030 m1 granted with m1_lock high for 3 cycles while m0 requests -> m0_waitrequest high throughout; m0 granted the cycle after the first cycle with m1_lock low.
REQ-031 m0 read granted, reset high the next cycle -> m0_readdatavalid stays 0, all regs 0, FSM IDLE; first tie after reset goes to m0.
REQ-032 m0 read + write both high, addr 0, data 32'h5A5A5A5A -> word0 written, m0_readdatavalid stays 0.
